fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential PC increment.
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1  SHALL be the synchronous reset, active-low.
REQ-005 pc_src  input  2  SHALL be the registered redirect select: 00 sequential, 01 branch, 10 jump, 11 treated as 00.
REQ-006 branch_target  input  32  SHALL be the target used when pc_src=01.
REQ-007 jump_target  input  32  SHALL be the target used when pc_src=10.
REQ-008 stall  input  1  SHALL be the pipeline stall request: no new fetch is issued while high.
REQ-009 imem_ack  input  1  SHALL be the instruction-memory completion strobe for the outstanding request.
REQ-010 imem_req  output  1  SHALL be the instruction-memory request.
REQ-011 imem_addr  output  32  SHALL be the fetch address, valid while imem_req=1.
REQ-012 pc  output  32  SHALL be the address of the last accepted instruction.
REQ-013 pc_valid  output  1  SHALL be a one-cycle pulse marking a new accepted pc.
REQ-014 flush  output  1  SHALL be a one-cycle pulse telling downstream to kill wrong-path instructions.

Function
REQ-015 States SHALL be IDLE, REQ and HOLD; the block holds a fetch-address register (fpc) and a pending-redirect register (pend_valid, pend_addr).
REQ-016 A redirect SHALL be any cycle with pc_src=01 or 10; its target is branch_target or jump_target respectively.
REQ-017 Every redirect SHALL produce flush=1 in the following cycle, with exactly one flush pulse per redirect cycle.
REQ-018 IDLE: the block SHALL go to REQ the next cycle, or to HOLD if stall=1.
REQ-019 REQ: imem_req=1 and imem_addr=fpc; imem_addr and imem_req SHALL stay constant until imem_ack=1, and a request is never retracted.
REQ-020 REQ with imem_ack=1, no redirect this cycle, and pend_valid=0: pc<=fpc, pc_valid=1 next cycle, fpc<=fpc+PC_STEP modulo 2^32; the block stays in REQ if stall=0, else goes to HOLD.
REQ-021 REQ with imem_ack=1 and a redirect this cycle or pend_valid=1: the instruction SHALL be discarded (pc_valid=0, pc unchanged), fpc<=target (a same-cycle redirect wins over pend_addr), pend_valid<=0.
REQ-022 REQ with imem_ack=0 and a redirect: pend_addr<=target, pend_valid<=1; a later redirect overwrites it (newest wins).
REQ-023 IDLE or HOLD with a redirect: fpc<=target directly, pend_valid unaffected/cleared.
REQ-024 HOLD: imem_req=0; the block SHALL return to REQ the cycle after stall=0, first applying pend_addr to fpc if pend_valid=1.
REQ-025 imem_ack outside REQ SHALL be ignored.

Reset
REQ-026 With reset_n=0 at a rising edge: state=IDLE, fpc=RESET_PC, pc=RESET_PC, pend_valid=0, imem_req=0, pc_valid=0, flush=0; this includes reset mid-request, where the outstanding fetch is abandoned and a late imem_ack is ignored.

Configuration
REQ-027 Macro REDIRECT_CNT_EN defined: the block SHALL add output redirect_count[15:0], reset to 0, incremented once per redirect cycle, saturating at 16'hFFFF; macro undefined: the port and counter SHALL be absent and all other behaviour is identical.

Verification
REQ-028 Reset release, pc_src=00, stall=0, imem_ack one cycle after each request -> imem_addr 0x0, 0x4, 0x8 in sequence; pc_valid pulses with pc=0x0, 0x4, 0x8.
REQ-029 pc_src=01, branch_target=0x100, asserted while imem_addr=0x8 waits for ack, ack 3 cycles later -> flush pulse once, the 0x8 fetch is discarded, next imem_addr=0x100.
REQ-030 pc_src=10, jump_target=0x200, on the same cycle as imem_ack -> no pc_valid for that fetch, next imem_addr=0x200, one flush pulse.
REQ-031 stall=1 during an outstanding request, then pc_src=01 with target 0x40 in HOLD, stall low 5 cycles later -> imem_req=0 for HOLD duration, resume with imem_addr=0x40.
REQ-032 reset_n=0 while imem_req=1 at address 0x20, late imem_ack after reset -> imem_addr restarts at RESET_PC, no pc_valid for 0x20; with REDIRECT_CNT_EN, redirect_count=0.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// The fetch side (master) issues imem_req/imem_addr; the memory side (slave)
// answers with a single-cycle imem_ack for the outstanding request.
interface fetch_pc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/fetch_pc.sv
// Fetch program counter: issues instruction-memory requests, tracks the
// accepted pc, and applies branch/jump redirects.
// A redirect that arrives while a request is outstanding is held as pending
// and applied when that request completes. The completed instruction is
// then dropped.
// Optional feature: define REDIRECT_CNT_EN to add a saturating 16-bit
// redirect_count output.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic        stall,
    fetch_pc_if.master  imem,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush
`ifdef REDIRECT_CNT_EN
    ,
    output logic [15:0] redirect_count
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        imem_req_q, imem_req_d;

    logic        redirect;
    logic [31:0] target;

    // Redirect decode: 01 selects branch, 10 selects jump, 00/11 are sequential.
    always_comb begin
        redirect = (pc_src == 2'b01) || (pc_src == 2'b10);
        target   = (pc_src == 2'b10) ? jump_target : branch_target;
    end

    // Next-state and output computation for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pc_d         = pc_q;
        pc_valid_d   = 1'b0;
        flush_d      = redirect;

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fpc_d        = target;
                    pend_valid_d = 1'b0;
                end
                state_d = stall ? HOLD : REQ;
            end
            REQ: begin
                if (imem.imem_ack) begin
                    // A same-cycle redirect wins over an older pending one.
                    // Either redirect drops the returning instruction.
                    if (redirect) begin
                        fpc_d = target;
                    end else if (pend_valid_q) begin
                        fpc_d = pend_addr_q;
                    end else begin
                        pc_d       = fpc_q;
                        pc_valid_d = 1'b1;
                        fpc_d      = fpc_q + STEP;
                    end
                    pend_valid_d = 1'b0;
                    state_d      = stall ? HOLD : REQ;
                end else if (redirect) begin
                    // Address must stay stable until ack, so park the target.
                    pend_valid_d = 1'b1;
                    pend_addr_d  = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fpc_d        = target;
                    pend_valid_d = 1'b0;
                end else if (!stall && pend_valid_q) begin
                    fpc_d        = pend_addr_q;
                    pend_valid_d = 1'b0;
                end
                if (!stall) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        imem_req_d = (state_d == REQ);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fpc_q        <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pc_q         <= RESET_PC;
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            flush_q      <= flush_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = fpc_q;
    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
    assign flush          = flush_q;

`ifdef REDIRECT_CNT_EN
    logic [15:0] redirect_count_q;

    // Count redirect cycles, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            redirect_count_q <= '0;
        end else if (redirect && (redirect_count_q != '1)) begin
            redirect_count_q <= redirect_count_q + 16'd1;
        end
    end

    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_fetch_pc;

    logic        clock;
    logic        reset_n;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
`ifdef REDIRECT_CNT_EN
    logic [15:0] redirect_count;
`endif

    fetch_pc_if imem_bus ();

    fetch_pc #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .stall         (stall),
        .imem          (imem_bus),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .flush         (flush)
`ifdef REDIRECT_CNT_EN
        ,
        .redirect_count(redirect_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks what is outstanding and what should have happened.
    bit          m_fresh;      // just out of reset, no decision yet
    bit          m_fetching;   // a request is on the bus
    bit          m_pend;
    logic [31:0] m_pend_addr;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    bit          m_pcv;
    bit          m_flush;
    int unsigned m_cnt;

    task automatic model_step();
        bit          redir;
        logic [31:0] tgt;
        redir = (pc_src == 2'd1) || (pc_src == 2'd2);
        tgt   = (pc_src == 2'd2) ? jump_target : branch_target;
        if (!reset_n) begin
            m_fresh = 1; m_fetching = 0; m_pend = 0; m_pend_addr = '0;
            m_addr = 32'h0; m_pc = 32'h0; m_pcv = 0; m_flush = 0; m_cnt = 0;
        end else begin
            m_pcv   = 0;
            m_flush = redir;
            if (redir && m_cnt < 16'hFFFF) m_cnt++;
            if (m_fresh) begin
                if (redir) m_addr = tgt;
                m_fresh    = 0;
                m_fetching = !stall;
            end else if (m_fetching) begin
                if (imem_bus.imem_ack) begin
                    if (redir) m_addr = tgt;
                    else if (m_pend) m_addr = m_pend_addr;
                    else begin
                        m_pc   = m_addr;
                        m_pcv  = 1;
                        m_addr = m_addr + 32'd4;
                    end
                    m_pend     = 0;
                    m_fetching = !stall;
                end else if (redir) begin
                    m_pend      = 1;
                    m_pend_addr = tgt;
                end
            end else begin
                if (redir) begin
                    m_addr = tgt;
                    m_pend = 0;
                end else if (!stall && m_pend) begin
                    m_addr = m_pend_addr;
                    m_pend = 0;
                end
                if (!stall) m_fetching = 1;
            end
        end
    endtask

    // Advance one clock, update the model with the inputs seen at the edge,
    // then move to the sampling point.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        pc_src = 2'd0; branch_target = '0; jump_target = '0;
        stall = 0; imem_bus.imem_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_bus.imem_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_pcv got=%0b exp=0", pc_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", flush); end
`ifdef REDIRECT_CNT_EN
        checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", redirect_count); end
`endif
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a;
        do_reset();
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL seq_first req=%0b addr=%h exp req=1 addr=00000000", imem_bus.imem_req, imem_bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'(i) * 32'd4;
            imem_bus.imem_ack = 1;
            tick();
            checks++; if (pc_valid !== 1'b1 || pc !== exp_a) begin
                errors++; $display("FAIL seq_pc[%0d] pcv=%0b pc=%h exp pcv=1 pc=%h", i, pc_valid, pc, exp_a); end
            checks++; if (imem_bus.imem_addr !== exp_a + 32'd4) begin
                errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_bus.imem_addr, exp_a + 32'd4); end
        end
        imem_bus.imem_ack = 0;
        tick();
        checks++; if (pc_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hC) begin
            errors++; $display("FAIL seq_wait pcv=%0b req=%0b addr=%h exp 0 1 0000000c", pc_valid, imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_branch_pending();
        do_reset();
        tick();
        imem_bus.imem_ack = 1;
        tick();
        tick();
        imem_bus.imem_ack = 0;
        pc_src = 2'd1; branch_target = 32'h100;
        tick();
        checks++; if (flush !== 1'b1 || imem_bus.imem_addr !== 32'h8 || imem_bus.imem_req !== 1'b1) begin
            errors++; $display("FAIL br_flush flush=%0b addr=%h req=%0b exp 1 00000008 1", flush, imem_bus.imem_addr, imem_bus.imem_req); end
        pc_src = 2'd0; branch_target = '0;
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_once got=%0b exp=0", flush); end
        tick();
        imem_bus.imem_ack = 1;
        tick();
        checks++; if (pc_valid !== 1'b0 || pc !== 32'h4) begin
            errors++; $display("FAIL br_discard pcv=%0b pc=%h exp 0 00000004", pc_valid, pc); end
        checks++; if (imem_bus.imem_addr !== 32'h100 || flush !== 1'b0) begin
            errors++; $display("FAIL br_target addr=%h flush=%0b exp 00000100 0", imem_bus.imem_addr, flush); end
        tick();
        checks++; if (pc_valid !== 1'b1 || pc !== 32'h100) begin
            errors++; $display("FAIL br_accept pcv=%0b pc=%h exp 1 00000100", pc_valid, pc); end
        imem_bus.imem_ack = 0;
    endtask

    task automatic test_jump_with_ack();
        do_reset();
        tick();
        imem_bus.imem_ack = 1;
        tick();
        tick();
        pc_src = 2'd2; jump_target = 32'h200;
        tick();
        checks++; if (pc_valid !== 1'b0 || pc !== 32'h4) begin
            errors++; $display("FAIL jmp_discard pcv=%0b pc=%h exp 0 00000004", pc_valid, pc); end
        checks++; if (imem_bus.imem_addr !== 32'h200 || flush !== 1'b1) begin
            errors++; $display("FAIL jmp_target addr=%h flush=%0b exp 00000200 1", imem_bus.imem_addr, flush); end
        pc_src = 2'd0; imem_bus.imem_ack = 0;
        tick();
        checks++; if (flush !== 1'b0 || imem_bus.imem_addr !== 32'h200) begin
            errors++; $display("FAIL jmp_after flush=%0b addr=%h exp 0 00000200", flush, imem_bus.imem_addr); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        tick();
        stall = 1;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL st_noretract req=%0b addr=%h exp 1 00000000", imem_bus.imem_req, imem_bus.imem_addr); end
        imem_bus.imem_ack = 1;
        tick();
        checks++; if (pc_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL st_enter pcv=%0b req=%0b exp 1 0", pc_valid, imem_bus.imem_req); end
        imem_bus.imem_ack = 0;
        pc_src = 2'd1; branch_target = 32'h40;
        tick();
        checks++; if (flush !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL st_redir flush=%0b req=%0b exp 1 0", flush, imem_bus.imem_req); end
        pc_src = 2'd0;
        for (int i = 0; i < 4; i++) begin
            imem_bus.imem_ack = (i == 1);
            tick();
            checks++; if (imem_bus.imem_req !== 1'b0 || pc_valid !== 1'b0) begin
                errors++; $display("FAIL st_hold[%0d] req=%0b pcv=%0b exp 0 0", i, imem_bus.imem_req, pc_valid); end
        end
        imem_bus.imem_ack = 0;
        stall = 0;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin
            errors++; $display("FAIL st_resume req=%0b addr=%h exp 1 00000040", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        pc_src = 2'd1; branch_target = 32'h1C;
        tick();
        pc_src = 2'd0;
        imem_bus.imem_ack = 1;
        tick();
        imem_bus.imem_ack = 0;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20) begin
            errors++; $display("FAIL rst_setup req=%0b addr=%h exp 1 00000020", imem_bus.imem_req, imem_bus.imem_addr); end
        reset_n = 0;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b0 || pc !== 32'h0 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL rst_abandon req=%0b pc=%h pcv=%0b exp 0 00000000 0", imem_bus.imem_req, pc, pc_valid); end
        reset_n = 1;
        imem_bus.imem_ack = 1;
        tick();
        checks++; if (pc_valid !== 1'b0 || imem_bus.imem_addr !== 32'h0 || imem_bus.imem_req !== 1'b1) begin
            errors++; $display("FAIL rst_lateack pcv=%0b addr=%h req=%0b exp 0 00000000 1", pc_valid, imem_bus.imem_addr, imem_bus.imem_req); end
`ifdef REDIRECT_CNT_EN
        checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", redirect_count); end
`endif
        imem_bus.imem_ack = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset_n            = ($urandom_range(0, 99) != 0);
            stall              = ($urandom_range(0, 4) == 0);
            imem_bus.imem_ack  = ($urandom_range(0, 2) == 0);
            pc_src             = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            branch_target      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            jump_target        = $urandom & 32'hFFFF_FFFC;
            tick();
            checks++; if (imem_bus.imem_req !== m_fetching) begin
                errors++; $display("FAIL rnd_req c=%0d got=%0b exp=%0b", c, imem_bus.imem_req, m_fetching); end
            if (m_fetching) begin
                checks++; if (imem_bus.imem_addr !== m_addr) begin
                    errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_bus.imem_addr, m_addr); end
            end
            checks++; if (pc_valid !== m_pcv || pc !== m_pc) begin
                errors++; $display("FAIL rnd_pc c=%0d pcv=%0b pc=%h exp %0b %h", c, pc_valid, pc, m_pcv, m_pc); end
            checks++; if (flush !== m_flush) begin
                errors++; $display("FAIL rnd_flush c=%0d got=%0b exp=%0b", c, flush, m_flush); end
`ifdef REDIRECT_CNT_EN
            checks++; if (redirect_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, redirect_count, m_cnt); end
`endif
        end
        idle_inputs();
        reset_n = 1;
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch_pending();
        test_jump_with_ack();
        test_stall_hold();
        test_reset_mid_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
